// File: rtl/t65_bus_ctrl.sv
// Bus-cycle controller between the T65 core and the external bus: ADDR, STROBE (+waits), END.
// Optional macro T65_BUS_EXT_WAIT_EN stretches STROBE while wait_n is low.
module t65_bus_ctrl #(
  parameter int ADDR_W        = 24,
  parameter int WAIT_CYCLES   = 1,
  parameter bit IDLE_ON_DUMMY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              core_enable,
  input  logic [23:0]       core_addr,
  input  logic              core_r_not_w,
  input  logic              core_vda,
  input  logic              core_vpa,
  input  logic [7:0]        core_data_o,
  output logic [7:0]        core_data_i,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_r_not_w,
  output logic              bus_cs_n,
  output logic              bus_oe_n,
  output logic              bus_we_n,
  output logic [7:0]        data_o,
  output logic              data_oe,
  input  logic [7:0]        data_i,
  input  logic              wait_n
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_END} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_wait_cnt;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic                r_bus_r_not_w;
  logic                r_bus_cs_n;
  logic                r_bus_oe_n;
  logic                r_bus_we_n;
  logic [7:0]          r_data_o;
  logic                r_data_oe;
  logic [7:0]          r_core_data_i;
  logic                r_core_enable;

  logic                w_wait_ok;
  logic                w_sel;
  logic                w_rd;
  logic                w_wr;
  logic                w_unused;

`ifdef T65_BUS_EXT_WAIT_EN
  assign w_wait_ok = wait_n;
`else
  assign w_wait_ok = 1'b1;
`endif

  // Upper address bits beyond ADDR_W are dropped by design.
  assign w_unused = ^{wait_n, core_addr};

  assign w_sel = !(IDLE_ON_DUMMY && !core_vda && !core_vpa);
  // Strobe kind follows what was latched at ADDR, so core changes later are ignored.
  assign w_rd  =  r_bus_r_not_w & ~r_bus_cs_n;
  assign w_wr  = ~r_bus_r_not_w & ~r_bus_cs_n;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (run) w_next = S_ADDR;
      S_ADDR:   w_next = S_STROBE;
      S_STROBE: if (r_wait_cnt == 4'd0 && w_wait_ok) w_next = S_END;
      S_END:    w_next = run ? S_ADDR : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 4'd0;
      r_bus_addr    <= '0;
      r_bus_r_not_w <= 1'b1;
      r_bus_cs_n    <= 1'b1;
      r_bus_oe_n    <= 1'b1;
      r_bus_we_n    <= 1'b1;
      r_data_o      <= 8'h00;
      r_data_oe     <= 1'b0;
      r_core_data_i <= 8'hFF;
      r_core_enable <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_core_enable <= (w_next == S_END);
      unique case (w_next)
        S_ADDR: begin
          r_bus_addr    <= core_addr[ADDR_W-1:0];
          r_bus_r_not_w <= core_r_not_w;
          r_data_o      <= core_data_o;
          r_bus_cs_n    <= ~w_sel;
          r_bus_oe_n    <= 1'b1;
          r_bus_we_n    <= 1'b1;
          r_data_oe     <= 1'b0;
          r_wait_cnt    <= 4'(WAIT_CYCLES);
        end
        S_STROBE: begin
          r_bus_oe_n <= ~w_rd;
          r_bus_we_n <= ~w_wr;
          r_data_oe  <= w_wr;
          if (r_state == S_STROBE && r_wait_cnt != 4'd0)
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
        S_END: begin
          // cs_n, address and data_oe hold through END for write hold time.
          r_bus_oe_n <= 1'b1;
          r_bus_we_n <= 1'b1;
          if (w_rd) r_core_data_i <= data_i;
        end
        default: begin
          r_bus_cs_n <= 1'b1;
          r_bus_oe_n <= 1'b1;
          r_bus_we_n <= 1'b1;
          r_data_oe  <= 1'b0;
        end
      endcase
    end
  end

  assign core_enable = r_core_enable;
  assign core_data_i = r_core_data_i;
  assign bus_addr    = r_bus_addr;
  assign bus_r_not_w = r_bus_r_not_w;
  assign bus_cs_n    = r_bus_cs_n;
  assign bus_oe_n    = r_bus_oe_n;
  assign bus_we_n    = r_bus_we_n;
  assign data_o      = r_data_o;
  assign data_oe     = r_data_oe;

endmodule

// File: tb/tb_t65_bus_ctrl.sv
// Bench for t65_bus_ctrl: table of single transactions, hand sequences, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_t65_bus_ctrl;
  localparam int AW  = 16;
  localparam int WC  = 1;
  localparam int LAT = 3 + WC;
`ifdef T65_BUS_EXT_WAIT_EN
  localparam int XW = 3;
`else
  localparam int XW = 0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic          core_r_not_w = 1'b1, core_vda = 1'b0, core_vpa = 1'b0, wait_n = 1'b1;
  logic [23:0]   core_addr = '0;
  logic [7:0]    core_data_o = '0, data_i = '0;
  logic          core_enable, bus_r_not_w, bus_cs_n, bus_oe_n, bus_we_n, data_oe;
  logic [7:0]    core_data_i, data_o;
  logic [AW-1:0] bus_addr;

  int nvec = 0, nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  t65_bus_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(WC), .IDLE_ON_DUMMY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .core_enable(core_enable),
    .core_addr(core_addr), .core_r_not_w(core_r_not_w), .core_vda(core_vda),
    .core_vpa(core_vpa), .core_data_o(core_data_o), .core_data_i(core_data_i),
    .bus_addr(bus_addr), .bus_r_not_w(bus_r_not_w), .bus_cs_n(bus_cs_n),
    .bus_oe_n(bus_oe_n), .bus_we_n(bus_we_n), .data_o(data_o), .data_oe(data_oe),
    .data_i(data_i), .wait_n(wait_n)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one record per transaction, with a count of strobe cycles spent.
  bit            m_act = 0, m_str = 0, m_end = 0, m_sel = 0, m_rnw = 1;
  int            m_pos = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_wd = 8'h00, m_rd = 8'hFF;

  function automatic bit wait_ok();
`ifdef T65_BUS_EXT_WAIT_EN
    return wait_n;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_str = 0; m_end = 0; m_sel = 0; m_rnw = 1; m_pos = 0;
      m_addr = '0; m_wd = 8'h00; m_rd = 8'hFF;
    end else if (!m_act || m_end) begin
      m_end = 0;
      if (run) begin
        m_act = 1; m_str = 0; m_pos = 0;
        m_addr = core_addr[AW-1:0]; m_rnw = core_r_not_w; m_wd = core_data_o;
        m_sel = core_vda || core_vpa;
      end else m_act = 0;
    end else if (!m_str) begin
      m_str = 1; m_pos = 1;
    end else if (m_pos >= WC + 1 && wait_ok()) begin
      m_str = 0; m_end = 1;
      if (m_rnw && m_sel) m_rd = data_i;
    end else m_pos++;
  end

  always @(negedge clk) if (chk_en)
    chk("cycle_model",
        64'({core_enable, core_data_i, bus_addr, bus_r_not_w, bus_cs_n, bus_oe_n, bus_we_n, data_o, data_oe}),
        64'({m_end, m_rd, m_addr, m_rnw, !(m_act && m_sel), !(m_str && m_sel && m_rnw),
             !(m_str && m_sel && !m_rnw), m_wd, m_act && (m_str || m_end) && m_sel && !m_rnw}));

  typedef struct {
    logic rnw, vda, vpa; logic [23:0] addr; logic [7:0] wdata, din;
    logic [AW-1:0] exp_addr; int exp_cs, exp_oe, exp_we, exp_doe; logic [7:0] exp_rd;
  } vec_t;
  localparam int NV = 7;
  vec_t tv [NV];

  // One transaction with run dropped after ADDR; counts cycles of each strobe over 12 clocks.
  task automatic run_txn(input vec_t v, input int wrel,
                         output int cs, output int oe, output int we, output int doe,
                         output int en_n, output int en_at,
                         output logic [AW-1:0] a1, output logic [7:0] d1, output logic doe1);
    cs = 0; oe = 0; we = 0; doe = 0; en_n = 0; en_at = 0; a1 = '0; d1 = '0; doe1 = 1'b0;
    @(negedge clk);
    core_r_not_w = v.rnw; core_vda = v.vda; core_vpa = v.vpa;
    core_addr = v.addr; core_data_o = v.wdata; data_i = v.din;
    wait_n = (wrel == 0); run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) begin
        a1 = bus_addr; d1 = data_o; doe1 = data_oe; run = 1'b0;
        core_addr = 24'($urandom); core_data_o = 8'($urandom); core_r_not_w = 1'($urandom);
      end
      if (!bus_cs_n) cs++;
      if (!bus_oe_n) oe++;
      if (!bus_we_n) we++;
      if (data_oe)   doe++;
      if (core_enable) begin en_n++; en_at = c; end
      if (c == wrel) wait_n = 1'b1;
    end
  endtask

  initial begin
    int cs, oe, we, doe, en_n, en_at, en_mask;
    logic [AW-1:0] a1; logic [7:0] d1; logic doe1;

    tv[0] = '{1'b1, 1'b1, 1'b0, 24'h00FFFC, 8'h00, 8'hA5, 16'hFFFC, LAT, WC+1, 0, 0, 8'hA5};
    tv[1] = '{1'b0, 1'b1, 1'b0, 24'h012345, 8'h3C, 8'h77, 16'h2345, LAT, 0, WC+1, WC+2, 8'hA5};
    tv[2] = '{1'b1, 1'b0, 1'b0, 24'h00ABCD, 8'h00, 8'h11, 16'hABCD, 0, 0, 0, 0, 8'hA5};
    tv[3] = '{1'b1, 1'b0, 1'b1, 24'h00FF00, 8'h00, 8'h5A, 16'hFF00, LAT, WC+1, 0, 0, 8'h5A};
    tv[4] = '{1'b0, 1'b0, 1'b0, 24'h001111, 8'h99, 8'h22, 16'h1111, 0, 0, 0, 0, 8'h5A};
    tv[5] = '{1'b0, 1'b1, 1'b1, 24'hFFFFFF, 8'hC3, 8'h00, 16'hFFFF, LAT, 0, WC+1, WC+2, 8'h5A};
    tv[6] = '{1'b1, 1'b1, 1'b0, 24'h000000, 8'h00, 8'h00, 16'h0000, LAT, WC+1, 0, 0, 8'h00};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cs_n", 64'(bus_cs_n), 64'd1);
    chk("rst_oe_n", 64'(bus_oe_n), 64'd1);
    chk("rst_we_n", 64'(bus_we_n), 64'd1);
    chk("rst_rnw", 64'(bus_r_not_w), 64'd1);
    chk("rst_data_oe", 64'(data_oe), 64'd0);
    chk("rst_data_o", 64'(data_o), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_core_data_i", 64'(core_data_i), 64'hFF);
    chk("rst_enable", 64'(core_enable), 64'd0);
    chk_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_txn(tv[i], 0, cs, oe, we, doe, en_n, en_at, a1, d1, doe1);
      chk($sformatf("v%0d_addr", i), 64'(a1), 64'(tv[i].exp_addr));
      chk($sformatf("v%0d_data_o", i), 64'(d1), 64'(tv[i].wdata));
      chk($sformatf("v%0d_doe_in_addr", i), 64'(doe1), 64'd0);
      chk($sformatf("v%0d_cs_cycles", i), 64'(cs), 64'(tv[i].exp_cs));
      chk($sformatf("v%0d_oe_cycles", i), 64'(oe), 64'(tv[i].exp_oe));
      chk($sformatf("v%0d_we_cycles", i), 64'(we), 64'(tv[i].exp_we));
      chk($sformatf("v%0d_doe_cycles", i), 64'(doe), 64'(tv[i].exp_doe));
      chk($sformatf("v%0d_en_count", i), 64'(en_n), 64'd1);
      chk($sformatf("v%0d_en_at", i), 64'(en_at), 64'(LAT));
      chk($sformatf("v%0d_rdata", i), 64'(core_data_i), 64'(tv[i].exp_rd));
    end

    // External wait held low across three counter-expired strobe edges.
    run_txn(tv[0], WC + 5, cs, oe, we, doe, en_n, en_at, a1, d1, doe1);
    chk("xw_oe_cycles", 64'(oe), 64'(WC + 1 + XW));
    chk("xw_cs_cycles", 64'(cs), 64'(LAT + XW));
    chk("xw_en_at", 64'(en_at), 64'(LAT + XW));
    chk("xw_en_count", 64'(en_n), 64'd1);

    // Back-to-back write then read: enable period and write-to-read turnaround.
    @(negedge clk);
    core_r_not_w = 1'b0; core_vda = 1'b1; core_vpa = 1'b0; core_addr = 24'h004455;
    core_data_o = 8'hB4; data_i = 8'h6E; wait_n = 1'b1; run = 1'b1;
    en_mask = 0;
    for (int c = 1; c <= 2 * LAT + 2; c++) begin
      @(posedge clk); @(negedge clk);
      if (core_enable) en_mask |= (1 << c);
      if (c == 2) begin core_r_not_w = 1'b1; core_addr = 24'h000777; end
      if (c == LAT + 1) begin
        chk("b2b_doe_in_addr", 64'(data_oe), 64'd0);
        chk("b2b_cs_in_addr", 64'(bus_cs_n), 64'd0);
        chk("b2b_rnw", 64'(bus_r_not_w), 64'd1);
        run = 1'b0;
      end
    end
    chk("b2b_en_mask", 64'(en_mask), 64'((1 << LAT) | (1 << (2 * LAT))));
    chk("b2b_rdata", 64'(core_data_i), 64'h6E);

    // Asynchronous reset in the middle of a write strobe.
    @(negedge clk);
    core_r_not_w = 1'b0; core_vda = 1'b1; core_addr = 24'h000042; core_data_o = 8'hE7; run = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("mid_we_active", 64'(bus_we_n), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we_n", 64'(bus_we_n), 64'd1);
    chk("mid_rst_data_oe", 64'(data_oe), 64'd0);
    chk("mid_rst_cs_n", 64'(bus_cs_n), 64'd1);
    chk("mid_rst_addr", 64'(bus_addr), 64'd0);
    chk("mid_rst_core_data_i", 64'(core_data_i), 64'hFF);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_cs", 64'(bus_cs_n), 64'd1);

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      run = ($urandom_range(0, 9) < 8);
      core_addr = 24'($urandom); core_data_o = 8'($urandom); data_i = 8'($urandom);
      core_r_not_w = 1'($urandom); core_vda = 1'($urandom); core_vpa = 1'($urandom);
      wait_n = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    run = 1'b0; wait_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_idle_cs", 64'(bus_cs_n), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/t65_bus_ctrl.md
Name: t65_bus_ctrl

Overview:
- Generalised bus-cycle controller placed between the T65 core and the external memory/peripheral bus.
- Stretches each core bus cycle into a multi-phase external transaction: address setup, strobe, configurable wait states, then hold.
- Generates the core's clock-enable so the core only advances when a transaction completes.
- Provides a registered data-drive enable; the top level builds the tri-state pad from data_o/data_oe.

Parameters:
- ADDR_W, 24, external address width (16..24); bus_addr = core_addr[ADDR_W-1:0].
- WAIT_CYCLES, 1, extra strobe cycles per access (0..15).
- IDLE_ON_DUMMY, 1, when 1 a cycle with vda=vpa=0 keeps bus_cs_n high (dummy cycle); when 0 all cycles select.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  global run request; sampled only in IDLE and END.
- core_enable  out  1  one-cycle clock-enable pulse to the core.
- core_addr  in  24  core address.
- core_r_not_w  in  1  core direction, 1 = read.
- core_vda  in  1  core valid data address.
- core_vpa  in  1  core valid program address.
- core_data_o  in  8  core write data.
- core_data_i  out  8  registered read data to the core.
- bus_addr  out  ADDR_W  external address.
- bus_r_not_w  out  1  external direction.
- bus_cs_n  out  1  chip select.
- bus_oe_n  out  1  read strobe.
- bus_we_n  out  1  write strobe.
- data_o  out  8  write data to the pad.
- data_oe  out  1  pad drive enable.
- data_i  in  8  pad input data.
- wait_n  in  1  external wait request, active low.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; bus_cs_n, bus_oe_n, bus_we_n = 1; bus_r_not_w = 1; data_oe = 0; data_o = 0; bus_addr = 0; core_data_i = 8'hFF; core_enable = 0; wait counter = 0.
- Reset asserted mid-transaction: all strobes deassert and data_oe drops immediately (asynchronously). No partial write completes after reset release.
- IDLE:
  - All strobes high, data_oe = 0.
  - run = 1 -> ADDR.
- ADDR (1 cycle), on entry:
  - Latch core_addr, core_r_not_w and core_data_o into bus_addr, bus_r_not_w and data_o.
  - bus_cs_n = 0 unless (IDLE_ON_DUMMY && !core_vda && !core_vpa).
  - bus_oe_n, bus_we_n and data_oe stay deasserted; this is the turnaround slot between consecutive writes and reads.
  - -> STROBE; load wait counter with WAIT_CYCLES.
- STROBE (1+WAIT_CYCLES cycles minimum):
  - Read: bus_oe_n = 0.
  - Write: bus_we_n = 0, data_oe = 1.
  - Dummy cycle (cs_n high): no strobe asserted, timing identical.
  - Counter decrements each cycle; counter = 0 (and wait satisfied, see optional feature) -> END.
  - On that transition edge, a read captures data_i into core_data_i; a write or dummy cycle leaves core_data_i unchanged.
- END (1 cycle):
  - bus_oe_n and bus_we_n = 1. bus_cs_n, bus_addr and data_oe hold their values (write hold time).
  - core_enable = 1 for exactly this cycle.
  - run = 1 -> ADDR, else -> IDLE.
- Latency: an access takes 3+WAIT_CYCLES clocks, ADDR to END inclusive. Back-to-back accesses produce core_enable every 3+WAIT_CYCLES clocks.
- run dropping mid-transaction: the current transaction completes, including the core_enable pulse; the controller then parks in IDLE.
- core_enable is never asserted outside END, and at most once per transaction.
- Core inputs are sampled only at ADDR entry; changes during STROBE or END are ignored.
- WAIT_CYCLES = 0: STROBE lasts exactly one cycle.
- data_oe is never 1 while bus_r_not_w = 1.

Optional Feature:
- Macro: T65_BUS_EXT_WAIT_EN.
- Defined: in STROBE, after the counter reaches 0, the controller stays in STROBE while wait_n = 0 (sampled each clk), with strobes held. The controller exits to END on the first cycle with counter = 0 and wait_n = 1. There is no timeout.
- Not defined: wait_n is ignored (port kept, unused); STROBE length is fixed at 1+WAIT_CYCLES.

Test Plan:
- Reset release, run = 1, read at core_addr 24'h00FFFC, data_i = 8'hA5, WAIT_CYCLES = 1 -> bus_cs_n low 4 clocks; bus_oe_n low 2 clocks; core_data_i = 8'hA5; one core_enable pulse on clock 4.
- Write of 8'h3C to 24'h012345 with ADDR_W = 16 -> bus_addr = 16'h2345; bus_we_n low 2 clocks; data_oe high during STROBE and END; data_o = 8'h3C; data_oe low in the next ADDR.
- Dummy cycle with vda = vpa = 0, IDLE_ON_DUMMY = 1 -> bus_cs_n, bus_oe_n and bus_we_n stay high; core_enable still pulses after 3+WAIT_CYCLES clocks; core_data_i unchanged.
- run deasserted during STROBE -> transaction finishes, core_enable pulses once, controller enters IDLE; no further bus_cs_n assertion.
- rst_n asserted mid-write during STROBE -> bus_we_n = 1 and data_oe = 0 in the same cycle, no clock edge needed; after release, state is IDLE with all reset values.
- With T65_BUS_EXT_WAIT_EN defined, WAIT_CYCLES = 0, wait_n held low 3 clocks -> STROBE lasts 4 clocks; without the macro, STROBE lasts 1 clock.
